// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// Used by both the APB requester (apb_master) and the APB completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W = 10;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master.sv
// APB requester: takes valid/ready commands and runs one APB transfer per
// command, returning a single-cycle response pulse.
// Optional build macro APB_MASTER_TIMEOUT_EN adds an ACCESS wait-state
// counter that aborts a transfer after TIMEOUT_CYCLES cycles without pready.
// All outputs come from registers or decode of the state register.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rnw_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q;
  logic       rsp_err_q;

  // Wait counter: cleared while in SETUP so it starts at 0 on ACCESS entry,
  // then counts ACCESS cycles that saw no pready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  wait_cnt_q <= '0;
    else if (state_q == SETUP)                  wait_cnt_q <= '0;
    else if (state_q == ACCESS && !pready_i)    wait_cnt_q <= wait_cnt_q + 8'd1;
  end

  // Expiry only matters when pready is low; pready wins in the next-state logic.
  assign timeout_hit = (state_q == ACCESS) && (wait_cnt_q == TO_LAST);

  // Error flag travels with the response pulse of an aborted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_err_q <= 1'b0;
    else       rsp_err_q <= timeout_hit && !pready_i;
  end

  assign rsp_err_o = rsp_err_q;
`else
  // No counter in this build: ACCESS waits for pready indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign rsp_err_o          = 1'b0;
`endif

  // Next-state and register-update decode for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwrite_d = !cmd_rnw_i;
          pwdata_d = cmd_wdata_i;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          rsp_valid_d = 1'b1;
          if (!pwrite_q) rsp_rdata_d = prdata_i;
          state_d = IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus/response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign cmd_ready_o = (state_q == IDLE) && !reset;
  assign psel_o      = (state_q != IDLE);
  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
